uart_boot_loader: RTL and testbench

Serial program loader upstream of the MCU instruction memory. It pops bytes from the UART receive FIFO and parses a framed image: sync byte, word count, payload, checksum. It assembles little-endian 32-bit words and writes them into instruction memory. It holds the RISC-V core in reset until a valid image has been loaded.

---
 rtl/uart_boot_loader.sv | 147 ++++++++++++++
 tb/tb_uart_boot_loader.sv | 288 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_boot_loader.sv
// Serial image loader: parses SYNC | len16 | payload words | checksum from the UART FIFO,
// writes little-endian words into instruction memory and releases the core on success.
//
// state | meaning
// IDLE  | hunting for SYNC, other bytes discarded
// LEN0  | waiting for count[7:0]
// LEN1  | waiting for count[15:8]
// DATA  | assembling payload words, one write per 4 bytes
// CSUM  | waiting for checksum byte
// DONE  | image accepted, core released, FIFO left alone
// ERR   | frame rejected, discarding bytes until the next SYNC
module uart_boot_loader #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] BASE_ADDR = '0,
  parameter int               MAX_WORDS = 1024,
  parameter int               TIMEOUT   = 2_000_000,
  parameter logic [7:0]       SYNC      = 8'hA5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             rx_empty,
  input  logic [7:0]       rx_data,
  output logic             rd_uart,
  output logic             imem_wen,
  output logic [WIDTH-1:0] imem_addr,
  output logic [WIDTH-1:0] imem_wdata,
  output logic             core_hold,
  output logic             done,
  output logic             error
);

  typedef enum logic [2:0] {IDLE, LEN0, LEN1, DATA, CSUM, DONE, ERR} state_t;

  localparam int              TW      = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
  localparam logic [TW-1:0]   TLOAD   = TW'(TIMEOUT - 2);
  localparam logic [16:0]     MAX_LIM = 17'(MAX_WORDS);

  state_t        state, state_nx;
  logic          pop, pop_q, is_sync, timed, tmo_hit, last_word;
  logic [15:0]   count_q, word_idx, len_nx;
  logic [1:0]    byte_idx;
  logic [23:0]   word_buf;
  logic [7:0]    csum;
  logic [TW-1:0] tmo_cnt;

  // Pops are spaced by at least one idle cycle so the FIFO head can advance.
  assign pop       = !reset && !rx_empty && !pop_q && (state != DONE);
  assign rd_uart   = pop;
  assign is_sync   = (rx_data == SYNC);
  assign timed     = (state == LEN0) || (state == LEN1) || (state == DATA) || (state == CSUM);
  assign tmo_hit   = timed && !pop && (tmo_cnt == '0);
  assign len_nx    = {rx_data, count_q[7:0]};
  assign last_word = (byte_idx == 2'd3) && (word_idx == (count_q - 16'd1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      done      <= 1'b0;
      error     <= 1'b0;
      core_hold <= 1'b1;
    end else begin
      state     <= state_nx;
      done      <= (state_nx == DONE);
      error     <= (state_nx == ERR);
      core_hold <= (state_nx != DONE);
    end
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE: if (pop && is_sync) state_nx = LEN0;
      LEN0: if (pop) state_nx = LEN1;
      LEN1: begin
        if (pop) begin
          if ({1'b0, len_nx} > MAX_LIM) state_nx = ERR;
          else if (len_nx == 16'd0)     state_nx = CSUM;
          else                          state_nx = DATA;
        end
      end
      DATA: if (pop && last_word) state_nx = CSUM;
      CSUM: if (pop) state_nx = (rx_data == csum) ? DONE : ERR;
      ERR:  if (pop && is_sync) state_nx = LEN0;
      DONE: state_nx = DONE;
      default: state_nx = IDLE;
    endcase
    if (tmo_hit) state_nx = ERR;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pop_q      <= 1'b0;
      count_q    <= '0;
      word_idx   <= '0;
      byte_idx   <= '0;
      word_buf   <= '0;
      csum       <= '0;
      tmo_cnt    <= TLOAD;
      imem_wen   <= 1'b0;
      imem_addr  <= BASE_ADDR;
      imem_wdata <= '0;
    end else begin
      pop_q    <= pop;
      imem_wen <= 1'b0;

      if (pop)                  tmo_cnt <= TLOAD;
      else if (tmo_cnt != '0)   tmo_cnt <= tmo_cnt - 1'b1;

      if (pop) begin
        case (state)
          IDLE, ERR: begin
            if (is_sync) begin
              csum     <= '0;
              byte_idx <= '0;
              word_idx <= '0;
            end
          end
          LEN0: begin
            count_q[7:0] <= rx_data;
            csum         <= csum + rx_data;
          end
          LEN1: begin
            count_q[15:8] <= rx_data;
            csum          <= csum + rx_data;
          end
          DATA: begin
            csum     <= csum + rx_data;
            byte_idx <= byte_idx + 2'd1;
            case (byte_idx)
              2'd0: word_buf[7:0]   <= rx_data;
              2'd1: word_buf[15:8]  <= rx_data;
              2'd2: word_buf[23:16] <= rx_data;
              default: begin
                imem_wen   <= 1'b1;
                imem_addr  <= BASE_ADDR + WIDTH'({word_idx, 2'b00});
                imem_wdata <= WIDTH'({rx_data, word_buf});
                word_idx   <= word_idx + 16'd1;
              end
            endcase
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_boot_loader.sv
// Scoreboard bench for uart_boot_loader: a frame-level parser predicts writes and
// done/error events, a monitor compares them against what the DUT presents.
module tb_uart_boot_loader;

  localparam int         MAX_W  = 1024;
  localparam int         TMO    = 100;
  localparam logic [7:0] SYNC_B = 8'hA5;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    int          pos;
  } wr_t;

  typedef struct {
    bit kind;  // 0: done rises, 1: error rises
    int pos;
    int off;
  } ev_t;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        rx_empty = 1'b1;
  logic [7:0]  rx_data = 8'h00;
  logic        rd_uart, imem_wen, core_hold, done, error;
  logic [31:0] imem_addr, imem_wdata;

  logic [7:0] fifo[$];
  logic [7:0] stim[$];
  wr_t        wr_q[$];
  ev_t        ev_q[$];
  int         pop_cyc[$];
  int         cyc = 0;
  int         npops = 0;
  int         nwr = 0;
  int         gap_pct = 0;
  int         checks = 0;
  int         errors = 0;
  int         exp_pops, n_exp_wr;
  bit         exp_done, exp_err;
  logic       done_prev = 1'b0;
  logic       error_prev = 1'b0;

  uart_boot_loader #(
    .WIDTH(32), .BASE_ADDR(32'h0), .MAX_WORDS(MAX_W), .TIMEOUT(TMO), .SYNC(SYNC_B)
  ) dut (
    .clock(clock), .reset(reset), .rx_empty(rx_empty), .rx_data(rx_data),
    .rd_uart(rd_uart), .imem_wen(imem_wen), .imem_addr(imem_addr),
    .imem_wdata(imem_wdata), .core_hold(core_hold), .done(done), .error(error)
  );

  initial forever #5 clock = ~clock;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // FIFO model: pops happen on the edge where rd_uart is high
  always @(posedge clock) begin
    if (rd_uart) begin
      if (fifo.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL pop_empty: rd_uart with empty fifo at cycle %0d", cyc);
      end else begin
        void'(fifo.pop_front());
      end
      pop_cyc.push_back(cyc);
      npops++;
    end
    cyc++;
  end

  initial forever begin
    @(negedge clock);
    rx_empty = (fifo.size() == 0) || ($urandom_range(0, 99) < gap_pct);
    rx_data  = (fifo.size() != 0) ? fifo[0] : 8'h00;
  end

  // Monitor: compares each write and each done/error rise against the scoreboard
  initial forever begin
    @(negedge clock);
    if (!reset) begin
      if (imem_wen) begin
        nwr++;
        if (wr_q.size() == 0) begin
          chk("unexpected_write_addr", imem_addr, 64'hFFFF_FFFF_FFFF);
        end else begin
          wr_t e;
          e = wr_q.pop_front();
          chk("wr_addr", imem_addr, e.addr);
          chk("wr_data", imem_wdata, e.data);
          if (e.pos < pop_cyc.size()) chk("wr_cycle", cyc, pop_cyc[e.pos] + 1);
          else chk("wr_trigger_popped", pop_cyc.size(), e.pos + 1);
        end
      end
      if ((done && !done_prev) || (error && !error_prev)) begin
        if (ev_q.size() == 0) begin
          chk("unexpected_event_done_error", {done, error}, 2'b00);
        end else begin
          ev_t e;
          e = ev_q.pop_front();
          chk("event_kind_error", error && !error_prev, e.kind);
          if (e.pos < pop_cyc.size()) chk("event_cycle", cyc, pop_cyc[e.pos] + e.off);
          else chk("event_trigger_popped", pop_cyc.size(), e.pos + 1);
        end
      end
    end
    done_prev  = done;
    error_prev = error;
  end

  // Frame-level reference: scans the byte stream by the framing rules
  task automatic timeout_ev();
    ev_q.push_back('{kind: 1'b1, pos: stim.size() - 1, off: TMO});
    exp_err = 1'b1;
  endtask

  task automatic model();
    int i, len, p, c, sum;
    bit fin, trunc;
    logic [31:0] w;
    i = 0; fin = 0; exp_done = 0; exp_err = 0; n_exp_wr = 0;
    while (i < stim.size() && !fin) begin
      if (stim[i] != SYNC_B) begin i++; continue; end
      exp_err = 1'b0;
      if (i + 2 >= stim.size()) begin timeout_ev(); break; end
      len = int'(stim[i+1]) + 256 * int'(stim[i+2]);
      sum = int'(stim[i+1]) + int'(stim[i+2]);
      if (len > MAX_W) begin
        ev_q.push_back('{kind: 1'b1, pos: i + 2, off: 1});
        exp_err = 1'b1;
        i += 3;
        continue;
      end
      p = i + 3;
      trunc = 0;
      for (int k = 0; k < len; k++) begin
        if (p + 4*k + 3 >= stim.size()) begin trunc = 1; break; end
        w = {stim[p+4*k+3], stim[p+4*k+2], stim[p+4*k+1], stim[p+4*k]};
        for (int b = 0; b < 4; b++) sum += int'(stim[p+4*k+b]);
        wr_q.push_back('{addr: 32'(4*k), data: w, pos: p + 4*k + 3});
        n_exp_wr++;
      end
      c = p + 4*len;
      if (trunc || c >= stim.size()) begin timeout_ev(); break; end
      if ((sum % 256) == int'(stim[c])) begin
        ev_q.push_back('{kind: 1'b0, pos: c, off: 1});
        fin = 1;
      end else begin
        ev_q.push_back('{kind: 1'b1, pos: c, off: 1});
        exp_err = 1'b1;
      end
      i = c + 1;
    end
    exp_pops = fin ? i : stim.size();
    exp_done = fin;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    fifo.delete(); wr_q.delete(); ev_q.delete(); pop_cyc.delete();
    npops = 0; nwr = 0;
    repeat (3) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic check_reset_vals(input string tag);
    chk({tag, "_rd_uart"}, rd_uart, 1'b0);
    chk({tag, "_imem_wen"}, imem_wen, 1'b0);
    chk({tag, "_imem_addr"}, imem_addr, 32'h0);
    chk({tag, "_imem_wdata"}, imem_wdata, 32'h0);
    chk({tag, "_core_hold"}, core_hold, 1'b1);
    chk({tag, "_done"}, done, 1'b0);
    chk({tag, "_error"}, error, 1'b0);
  endtask

  task automatic run_stream(input string tag);
    bit quiet;
    model();
    foreach (stim[k]) fifo.push_back(stim[k]);
    quiet = 0;
    for (int k = 0; k < 3000 && !quiet; k++) begin
      @(negedge clock);
      quiet = (wr_q.size() == 0) && (ev_q.size() == 0) && (npops == exp_pops);
    end
    if (!quiet) begin
      checks++;
      errors++;
      $display("FAIL %s_wait: pops %0d expected %0d, pending writes %0d, pending events %0d",
               tag, npops, exp_pops, wr_q.size(), ev_q.size());
    end
    repeat (6) @(negedge clock);
    chk({tag, "_pops"}, npops, exp_pops);
    chk({tag, "_writes"}, nwr, n_exp_wr);
    chk({tag, "_done"}, done, exp_done);
    chk({tag, "_error"}, error, exp_err);
    chk({tag, "_core_hold"}, core_hold, !exp_done);
  endtask

  task automatic add_nominal(input logic [7:0] ck);
    stim.push_back(8'hA5); stim.push_back(8'h02); stim.push_back(8'h00);
    stim.push_back(8'h13); stim.push_back(8'h00); stim.push_back(8'h00); stim.push_back(8'h00);
    stim.push_back(8'h93); stim.push_back(8'h00); stim.push_back(8'h10); stim.push_back(8'h00);
    stim.push_back(ck);
  endtask

  task automatic gen_random();
    int nf, len, sum;
    logic [7:0] b;
    stim.delete();
    nf = $urandom_range(1, 3);
    for (int f = 0; f < nf; f++) begin
      for (int g = $urandom_range(0, 3); g > 0; g--) begin
        b = 8'($urandom_range(0, 255));
        if (b == SYNC_B) b = 8'h00;
        stim.push_back(b);
      end
      if ($urandom_range(0, 9) == 0) begin
        len = $urandom_range(MAX_W + 1, MAX_W + 80);
        stim.push_back(SYNC_B); stim.push_back(8'(len)); stim.push_back(8'(len >> 8));
      end else begin
        len = $urandom_range(0, 4);
        stim.push_back(SYNC_B); stim.push_back(8'(len)); stim.push_back(8'h00);
        sum = len;
        for (int k = 0; k < 4*len; k++) begin
          b = 8'($urandom_range(0, 255));
          sum += int'(b);
          stim.push_back(b);
        end
        stim.push_back(($urandom_range(0, 3) == 0) ? 8'(sum + 1) : 8'(sum));
      end
    end
  endtask

  initial begin
    repeat (2) @(negedge clock);
    check_reset_vals("por");
    do_reset();

    stim.delete(); add_nominal(8'hB8);
    run_stream("nominal");

    do_reset();
    stim = {8'h00, 8'hFF, 8'h5A}; add_nominal(8'hB8);
    run_stream("garbage");

    do_reset();
    stim.delete(); add_nominal(8'hB9); add_nominal(8'hB8);
    run_stream("badcsum_reload");

    do_reset();
    stim = {8'hA5, 8'h01, 8'h04};
    run_stream("oversize");

    do_reset();
    stim = {8'hA5, 8'h01, 8'h00, 8'h13};
    run_stream("timeout");

    do_reset();
    stim = {8'hA5, 8'h02, 8'h00, 8'h13, 8'h00};
    foreach (stim[k]) fifo.push_back(stim[k]);
    for (int k = 0; k < 200 && npops < 5; k++) @(negedge clock);
    chk("mid_reset_pops", npops, 5);
    @(negedge clock);
    reset = 1'b1;
    #1;
    check_reset_vals("mid");
    do_reset();
    stim = {8'hA5, 8'h00, 8'h00, 8'h00};
    run_stream("zero_count");

    for (int t = 0; t < 25; t++) begin
      do_reset();
      gap_pct = $urandom_range(0, 40);
      gen_random();
      run_stream("random");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
